// File: rtl/ttt_pkg.sv
// Shared tic-tac-toe definitions: debounce FSM states, position limit, owner codes.
package ttt_pkg;

  typedef enum logic [1:0] {
    REL  = 2'd0,
    PCHK = 2'd1,
    PRS  = 2'd2,
    RCHK = 2'd3
  } db_state_e;

  localparam logic [3:0] POS_MAX        = 4'd8;
  localparam logic [1:0] OWNER_PLAYER   = 2'b01;
  localparam logic [1:0] OWNER_COMPUTER = 2'b10;

endpackage

// File: rtl/btn_debounce.sv
// Single button front end: 2-flop synchroniser, press/release debounce FSM, and a
// combinational accept strobe asserted on the cycle a press is confirmed.
module btn_debounce
  import ttt_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clock,
  input  logic reset_n,
  input  logic btn,
  output logic accept
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             btn_meta;
  logic             synced;
  db_state_e        state;
  logic [CNT_W-1:0] cnt;

  // Two-flop synchroniser for the asynchronous raw button.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      btn_meta <= 1'b0;
      synced   <= 1'b0;
    end else begin
      btn_meta <= btn;
      synced   <= btn_meta;
    end
  end

  // Debounce FSM: any mismatching sample drops back and restarts the count.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= REL;
      cnt   <= '0;
    end else begin
      case (state)
        REL: begin
          if (synced) state <= PCHK;
          cnt <= '0;
        end
        PCHK: begin
          if (!synced) begin
            state <= REL;
            cnt   <= '0;
          end else if (cnt == LAST) begin
            state <= PRS;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        PRS: begin
          if (!synced) state <= RCHK;
          cnt <= '0;
        end
        RCHK: begin
          if (synced) begin
            state <= PRS;
            cnt   <= '0;
          end else if (cnt == LAST) begin
            state <= REL;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= REL;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Accept fires exactly on the PCHK->PRS transition cycle.
  assign accept = (state == PCHK) && synced && (cnt == LAST);

endmodule

// File: rtl/move_input_conditioner.sv
// Tic-tac-toe input front end: debounced single-cycle play/pc pulses and latched
// switch positions. Define POS_RANGE_CHECK_EN to reject positions above 8 with a
// bad_pos pulse instead of a play/pc pulse.
module move_input_conditioner
  import ttt_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       play_btn,
  input  logic       pc_btn,
  input  logic [3:0] player_sw,
  input  logic [3:0] computer_sw,
  output logic       play,
  output logic       pc,
  output logic [3:0] player_position,
  output logic [3:0] computer_position,
  output logic       bad_pos
);

  logic       play_acc, pc_acc;
  logic [3:0] player_sw_meta, player_sw_sync;
  logic [3:0] computer_sw_meta, computer_sw_sync;
  logic       play_ok, pc_ok, play_bad, pc_bad;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_play_db (
    .clock  (clock),
    .reset_n(reset_n),
    .btn    (play_btn),
    .accept (play_acc)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_pc_db (
    .clock  (clock),
    .reset_n(reset_n),
    .btn    (pc_btn),
    .accept (pc_acc)
  );

  // Switch synchronisers share the button latency so a switch set with the button is seen.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      player_sw_meta   <= '0;
      player_sw_sync   <= '0;
      computer_sw_meta <= '0;
      computer_sw_sync <= '0;
    end else begin
      player_sw_meta   <= player_sw;
      player_sw_sync   <= player_sw_meta;
      computer_sw_meta <= computer_sw;
      computer_sw_sync <= computer_sw_meta;
    end
  end

`ifdef POS_RANGE_CHECK_EN
  assign play_bad = play_acc && (player_sw_sync > POS_MAX);
  assign pc_bad   = pc_acc && (computer_sw_sync > POS_MAX);
`else
  assign play_bad = 1'b0;
  assign pc_bad   = 1'b0;
`endif
  assign play_ok = play_acc && !play_bad;
  assign pc_ok   = pc_acc && !pc_bad;

  // Registered pulses; positions load on the same edge their pulse rises.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      play              <= 1'b0;
      pc                <= 1'b0;
      bad_pos           <= 1'b0;
      player_position   <= '0;
      computer_position <= '0;
    end else begin
      play    <= play_ok;
      pc      <= pc_ok;
      bad_pos <= play_bad || pc_bad;
      if (play_ok) player_position   <= player_sw_sync;
      if (pc_ok)   computer_position <= computer_sw_sync;
    end
  end

endmodule
